// File: rtl/lock_ctrl_pkg.sv
// Shared types, constants and the binary-to-BCD helper for the lock attempt controller.
package lock_ctrl_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        LOCKOUT = 1'b1
    } state_t;

    // Largest two-digit BCD value and its binary equivalent.
    localparam logic [7:0] BCD_MAX   = 8'h99;
    localparam int         BIN_CLAMP = 99;

    // Converts a binary value in 0..99 to two BCD digits, tens digit in [7:4].
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        return (8'(bin / 7'd10) << 4) | 8'(bin % 7'd10);
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with parallel load, decrement enable and zero flag.
// Decrementing is suppressed at 00 so the count never wraps to 99.
module bcd_down_counter
    import lock_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec_en,
    output logic [7:0] count,
    output logic       zero
);

    logic [1:0][3:0] digit_reg;
    logic [1:0][3:0] digit_next;
    logic [1:0]      borrow;

    assign zero      = (digit_reg == '0);
    assign borrow[0] = dec_en && !zero;

    // Per-digit decrement; a digit at 0 rolls to 9 and borrows from the next digit.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            assign digit_next[gi] = !borrow[gi]            ? digit_reg[gi] :
                                    (digit_reg[gi] == 4'd0) ? 4'd9 :
                                                              digit_reg[gi] - 4'd1;
            if (gi < 1) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (digit_reg[gi] == 4'd0);
            end
        end
    endgenerate

    // Count register: load has priority over decrement; oversize loads saturate at 99.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= (load_value > BCD_MAX) ? BCD_MAX : load_value;
        end else begin
            digit_reg <= digit_next;
        end
    end

    assign count = digit_reg;

endmodule

// File: rtl/lock_attempt_controller.sv
// Forwards key pulses to the lock FSM, counts consecutive failed attempts and
// enforces an escalating timed lockout with a BCD seconds countdown.
module lock_attempt_controller
    import lock_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 50000000,
    parameter int LOCKOUT_SECS   = 10,
    parameter int MAX_FAILS      = 3,
    parameter int MAX_ESCALATION = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_in,
    input  logic       fsm_error,
    input  logic       fsm_locked,
    output logic [3:0] key_out,
    output logic       lockout_flag,
    output logic [3:0] fail_count,
    output logic [7:0] lockout_bcd
);

    localparam int PRESC_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam int LEVEL_W = (MAX_ESCALATION > 0) ? $clog2(MAX_ESCALATION + 1) : 1;
    localparam int DUR_W   = 8 + MAX_ESCALATION;

    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(CYCLES_PER_SEC - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX    = LEVEL_W'(MAX_ESCALATION);
    localparam logic [3:0]         FAILS_LIMIT  = 4'(MAX_FAILS);

    state_t             state_reg, state_next;
    logic [3:0]         key_out_reg, key_next;
    logic [3:0]         fail_reg, fail_next, fail_inc;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic               error_d_reg, locked_d_reg;
    logic               key_pass, cnt_load, cnt_dec, cnt_zero;
    logic [7:0]         cnt_value, load_bcd;
    logic [DUR_W-1:0]   shifted_secs;
    logic [6:0]         clamped_secs;
    logic               fail_evt, success_evt;

    assign fail_evt    = fsm_error && !error_d_reg;
    assign success_evt = !fsm_locked && locked_d_reg;
    assign fail_inc    = fail_reg + 4'd1;

    // Lockout length for the current escalation level, clamped to 99 s.
    assign shifted_secs = DUR_W'(LOCKOUT_SECS) << level_reg;
    assign clamped_secs = (shifted_secs > DUR_W'(BIN_CLAMP)) ? 7'(BIN_CLAMP) : shifted_secs[6:0];
    assign load_bcd     = bin_to_bcd(clamped_secs);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_gate
            assign key_next[gi] = key_in[gi] && key_pass;
        end
    endgenerate

    bcd_down_counter u_countdown (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (load_bcd),
        .dec_en     (cnt_dec),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    // Next-state logic: failure counting in NORMAL, countdown and exit in LOCKOUT.
    always_comb begin
        state_next = state_reg;
        key_pass   = 1'b0;
        fail_next  = fail_reg;
        level_next = level_reg;
        presc_next = presc_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            NORMAL: begin
                key_pass = 1'b1;
                if (success_evt) begin
                    // A successful unlock outranks a simultaneous failure.
                    fail_next  = 4'd0;
                    level_next = '0;
                end else if (fail_evt) begin
                    if (fail_inc == FAILS_LIMIT) begin
                        state_next = LOCKOUT;
                        fail_next  = 4'd0;
                        cnt_load   = 1'b1;
                        presc_next = PRESC_RELOAD;
                        key_pass   = 1'b0;
                        level_next = (level_reg == LEVEL_MAX) ? level_reg : level_reg + 1'b1;
                    end else begin
                        fail_next = fail_inc;
                    end
                end
            end
            LOCKOUT: begin
                if (success_evt) begin
                    level_next = '0;
                end
                if (cnt_zero) begin
                    // Defensive exit; a loaded count is never zero.
                    state_next = NORMAL;
                    fail_next  = 4'd0;
                end else if (presc_reg == '0) begin
                    presc_next = PRESC_RELOAD;
                    cnt_dec    = 1'b1;
                    if (cnt_value == 8'h01) begin
                        state_next = NORMAL;
                        fail_next  = 4'd0;
                    end
                end else begin
                    presc_next = presc_reg - 1'b1;
                end
            end
            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    // State, counters, gated key register and edge-detect history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= NORMAL;
            key_out_reg  <= 4'd0;
            fail_reg     <= 4'd0;
            level_reg    <= '0;
            presc_reg    <= '0;
            error_d_reg  <= 1'b0;
            locked_d_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            key_out_reg  <= key_next;
            fail_reg     <= fail_next;
            level_reg    <= level_next;
            presc_reg    <= presc_next;
            error_d_reg  <= fsm_error;
            locked_d_reg <= fsm_locked;
        end
    end

    assign key_out      = key_out_reg;
    assign lockout_flag = (state_reg == LOCKOUT);
    assign fail_count   = fail_reg;
    assign lockout_bcd  = (state_reg == LOCKOUT) ? cnt_value : 8'h00;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Directed testbench for lock_attempt_controller with a 4-cycle second and 3 s base lockout.
module tb_lock_attempt_controller;

    localparam int CPS = 4;

    logic       clock;
    logic       reset;
    logic [3:0] key_in;
    logic       fsm_error;
    logic       fsm_locked;
    logic [3:0] key_out;
    logic       lockout_flag;
    logic [3:0] fail_count;
    logic [7:0] lockout_bcd;

    int errors = 0;
    int checks = 0;

    lock_attempt_controller #(
        .CYCLES_PER_SEC (CPS),
        .LOCKOUT_SECS   (3),
        .MAX_FAILS      (3),
        .MAX_ESCALATION (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_in       (key_in),
        .fsm_error    (fsm_error),
        .fsm_locked   (fsm_locked),
        .key_out      (key_out),
        .lockout_flag (lockout_flag),
        .fail_count   (fail_count),
        .lockout_bcd  (lockout_bcd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    // One isolated failure: error rises for one cycle then drops.
    task automatic fail_pulse();
        fsm_error = 1'b1;
        step();
        fsm_error = 1'b0;
        step();
    endtask

    // Third failure edge; returns on the first lockout cycle with error lowered.
    task automatic enter_lockout(input string name);
        fsm_error = 1'b1;
        step();
        fsm_error = 1'b0;
        checks++; if (lockout_flag !== 1'b1) begin errors++; $display("FAIL %s_entry lockout_flag=%0b expected=1", name, lockout_flag); end
        checks++; if (fail_count !== 4'd0) begin errors++; $display("FAIL %s_entry fail_count=%0d expected=0", name, fail_count); end
    endtask

    // Walks a full lockout from its first cycle, pressing keys, then checks the exit.
    task automatic check_countdown(input int secs, input string name);
        for (int c = 0; c < secs * CPS; c++) begin
            checks++; if (lockout_bcd !== to_bcd(secs - c / CPS)) begin errors++; $display("FAIL %s_bcd cycle=%0d lockout_bcd=%h expected=%h", name, c, lockout_bcd, to_bcd(secs - c / CPS)); end
            checks++; if (lockout_flag !== 1'b1) begin errors++; $display("FAIL %s_flag cycle=%0d lockout_flag=%0b expected=1", name, c, lockout_flag); end
            checks++; if (key_out !== 4'd0) begin errors++; $display("FAIL %s_keyblock cycle=%0d key_out=%b expected=0000", name, c, key_out); end
            key_in = (c % 3 == 1) ? 4'b0101 : 4'b0000;
            step();
        end
        key_in = 4'b0000;
        checks++; if (lockout_flag !== 1'b0) begin errors++; $display("FAIL %s_exit lockout_flag=%0b expected=0", name, lockout_flag); end
        checks++; if (lockout_bcd !== 8'h00) begin errors++; $display("FAIL %s_exit lockout_bcd=%h expected=00", name, lockout_bcd); end
        checks++; if (key_out !== 4'd0) begin errors++; $display("FAIL %s_exit key_out=%b expected=0000", name, key_out); end
        checks++; if (fail_count !== 4'd0) begin errors++; $display("FAIL %s_exit fail_count=%0d expected=0", name, fail_count); end
        $display("lockout %s: %0d s countdown done", name, secs);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        key_in     = 4'hF;
        fsm_error  = 1'b0;
        fsm_locked = 1'b0;
        repeat (3) step();
        checks++; if (key_out !== 4'd0) begin errors++; $display("FAIL reset key_out=%b expected=0000", key_out); end
        checks++; if (lockout_flag !== 1'b0) begin errors++; $display("FAIL reset lockout_flag=%0b expected=0", lockout_flag); end
        checks++; if (fail_count !== 4'd0) begin errors++; $display("FAIL reset fail_count=%0d expected=0", fail_count); end
        checks++; if (lockout_bcd !== 8'h00) begin errors++; $display("FAIL reset lockout_bcd=%h expected=00", lockout_bcd); end
        key_in = 4'h0;
        reset  = 1'b1;
        step();
        $display("reset: outputs idle");
    endtask

    task automatic test_key_forward();
        key_in = 4'b0010;
        checks++; if (key_out !== 4'd0) begin errors++; $display("FAIL key_early key_out=%b expected=0000", key_out); end
        step();
        key_in = 4'b0000;
        checks++; if (key_out !== 4'b0010) begin errors++; $display("FAIL key_forward key_out=%b expected=0010", key_out); end
        checks++; if (lockout_flag !== 1'b0) begin errors++; $display("FAIL key_flag lockout_flag=%0b expected=0", lockout_flag); end
        checks++; if (lockout_bcd !== 8'h00) begin errors++; $display("FAIL key_bcd lockout_bcd=%h expected=00", lockout_bcd); end
        step();
        checks++; if (key_out !== 4'd0) begin errors++; $display("FAIL key_single key_out=%b expected=0000", key_out); end
        $display("key forward: 0010 seen one cycle later");
    endtask

    task automatic test_escalation();
        int secs_tab [4] = '{3, 6, 12, 12};
        for (int n = 0; n < 4; n++) begin
            fail_pulse();
            checks++; if (fail_count !== 4'd1) begin errors++; $display("FAIL esc%0d_fail1 fail_count=%0d expected=1", n, fail_count); end
            fail_pulse();
            checks++; if (fail_count !== 4'd2) begin errors++; $display("FAIL esc%0d_fail2 fail_count=%0d expected=2", n, fail_count); end
            enter_lockout($sformatf("esc%0d", n));
            check_countdown(secs_tab[n], $sformatf("esc%0d", n));
        end
    endtask

    task automatic test_success_reset();
        fail_pulse();
        fail_pulse();
        checks++; if (fail_count !== 4'd2) begin errors++; $display("FAIL succ_pre fail_count=%0d expected=2", fail_count); end
        fsm_locked = 1'b1;
        step();
        fsm_locked = 1'b0;
        step();
        checks++; if (fail_count !== 4'd0) begin errors++; $display("FAIL succ_clear fail_count=%0d expected=0", fail_count); end
        checks++; if (lockout_flag !== 1'b0) begin errors++; $display("FAIL succ_flag lockout_flag=%0b expected=0", lockout_flag); end
        fail_pulse();
        fail_pulse();
        enter_lockout("succ");
        check_countdown(3, "succ");
    endtask

    task automatic test_coincident_and_hold();
        // Error held high for three cycles counts once.
        fsm_error = 1'b1;
        step();
        checks++; if (fail_count !== 4'd1) begin errors++; $display("FAIL hold_first fail_count=%0d expected=1", fail_count); end
        step();
        step();
        checks++; if (fail_count !== 4'd1) begin errors++; $display("FAIL hold_once fail_count=%0d expected=1", fail_count); end
        fsm_error = 1'b0;
        step();
        fail_pulse();
        checks++; if (fail_count !== 4'd2) begin errors++; $display("FAIL hold_second fail_count=%0d expected=2", fail_count); end
        // Key pressed on the cycle of the third failure edge is dropped.
        fsm_error = 1'b1;
        key_in    = 4'b1000;
        step();
        fsm_error = 1'b0;
        key_in    = 4'b0000;
        checks++; if (key_out !== 4'd0) begin errors++; $display("FAIL coinc_key key_out=%b expected=0000", key_out); end
        checks++; if (lockout_flag !== 1'b1) begin errors++; $display("FAIL coinc_flag lockout_flag=%0b expected=1", lockout_flag); end
        check_countdown(6, "coinc");
    endtask

    task automatic test_reset_mid_lockout();
        int waited = 0;
        fail_pulse();
        fail_pulse();
        enter_lockout("mid");
        checks++; if (lockout_bcd !== 8'h12) begin errors++; $display("FAIL mid_load lockout_bcd=%h expected=12", lockout_bcd); end
        while (lockout_bcd !== 8'h02 && waited < 100) begin
            step();
            waited++;
        end
        checks++; if (waited >= 100) begin errors++; $display("FAIL mid_wait lockout_bcd=%h expected=02 within 100 cycles", lockout_bcd); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (lockout_flag !== 1'b0) begin errors++; $display("FAIL mid_rst_flag lockout_flag=%0b expected=0", lockout_flag); end
        checks++; if (lockout_bcd !== 8'h00) begin errors++; $display("FAIL mid_rst_bcd lockout_bcd=%h expected=00", lockout_bcd); end
        checks++; if (key_out !== 4'd0) begin errors++; $display("FAIL mid_rst_key key_out=%b expected=0000", key_out); end
        checks++; if (fail_count !== 4'd0) begin errors++; $display("FAIL mid_rst_fail fail_count=%0d expected=0", fail_count); end
        step();
        step();
        reset = 1'b1;
        step();
        fail_pulse();
        fail_pulse();
        enter_lockout("post_rst");
        check_countdown(3, "post_rst");
    endtask

    initial begin
        test_reset();
        test_key_forward();
        test_escalation();
        test_success_reset();
        test_coincident_and_hold();
        test_reset_mid_lockout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
